pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enables of PC, IF_ID, ID_EX,
//  EX_MEM and MEM_WB. Inserts ID_EX bubbles on load-use hazards, flushes the wrong path on taken

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, action sets
// and the decode from an action to the pipeline-register controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_FREEZE,
    ACT_LDSTALL,
    ACT_FLUSH
  } action_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic       EN_LOAD  = 1'b0;
  localparam logic       EN_HOLD  = 1'b1;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic bubble;
    logic flush;
  } ctrl_t;

  function automatic ctrl_t decode_action(input action_e act);
    ctrl_t c;
    c = '{EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, 1'b0, 1'b0};
    case (act)
      ACT_FREEZE:  c = '{EN_HOLD, EN_HOLD, EN_HOLD, EN_HOLD, EN_HOLD, 1'b0, 1'b0};
      ACT_LDSTALL: c = '{EN_HOLD, EN_HOLD, EN_LOAD, EN_LOAD, EN_LOAD, 1'b1, 1'b0};
      ACT_FLUSH:   c = '{EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, 1'b1, 1'b1};
      default:     c = '{EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, EN_LOAD, 1'b0, 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs_id,
  input  logic       use_rt_id,
  input  logic [4:0] rt_ex,
  input  logic       flag_mem_rd_ex,
  output logic       load_use
);

  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = flag_mem_rd_ex && (rt_ex != REG_ZERO) &&
                    ((use_rs_id && (rs_id == rt_ex)) || (use_rt_id && (rt_id == rt_ex)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy control outputs,
// registered flush/busy/stall counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [4:0]       rt_ex,
  input  logic             flag_mem_rd_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  output logic             PC_enable,
  output logic             IF_ID_enable,
  output logic             ID_EX_enable,
  output logic             EX_MEM_enable,
  output logic             MEM_WB_enable,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int BUSY_W  = $clog2(MEM_TIMEOUT + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [BUSY_W-1:0]  BUSY_LIMIT   = BUSY_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_timeout_q, mem_timeout_d;
  action_e            action;
  ctrl_t              ctrl;
  logic               load_use;

  hazard_detect u_hazard_detect (
    .rs_id          (rs_id),
    .rt_id          (rt_id),
    .use_rs_id      (use_rs_id),
    .use_rt_id      (use_rt_id),
    .rt_ex          (rt_ex),
    .flag_mem_rd_ex (flag_mem_rd_ex),
    .load_use       (load_use)
  );

  // A pending flush (flush_cnt_q != 0) survives a memory wait and takes priority
  // over a new branch, which is on the wrong path at that point.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    busy_cnt_d    = busy_cnt_q;
    mem_timeout_d = mem_timeout_q;
    action        = ACT_NORMAL;

    if (mem_busy) begin
      action  = ACT_FREEZE;
      state_d = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        if (busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + 1'b1;
        if (busy_cnt_q >= BUSY_LIMIT) mem_timeout_d = 1'b1;
      end else begin
        busy_cnt_d = BUSY_W'(1);
      end
    end else begin
      busy_cnt_d = '0;
      if (flush_cnt_q != '0) begin
        action      = ACT_FLUSH;
        flush_cnt_d = flush_cnt_q - 1'b1;
        state_d     = (flush_cnt_q == FLUSH_W'(1)) ? RUN : FLUSH;
      end else if (branch_taken_ex) begin
        action = ACT_FLUSH;
        if (FLUSH_CYCLES > 1) begin
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = FLUSH;
        end else begin
          state_d = RUN;
        end
      end else if (load_use) begin
        action  = ACT_LDSTALL;
        state_d = RUN;
      end else begin
        state_d = RUN;
      end
    end

    stall_count_d = stall_count_q;
    if (action != ACT_NORMAL && stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      busy_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      busy_cnt_q    <= busy_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // During reset every register holds and both ID_EX bubble and IF_ID flush are forced.
  assign ctrl = rst ? '1 : decode_action(action);

  assign PC_enable     = ctrl.pc_en;
  assign IF_ID_enable  = ctrl.if_id_en;
  assign ID_EX_enable  = ctrl.id_ex_en;
  assign EX_MEM_enable = ctrl.ex_mem_en;
  assign MEM_WB_enable = ctrl.mem_wb_en;
  assign bubble_ID_EX  = ctrl.bubble;
  assign flush_IF_ID   = ctrl.flush;
  assign stall_count   = stall_count_q;
  assign mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 255;
  localparam int CNT_W        = 8;

  localparam logic [6:0] V_NORMAL  = 7'b0000000;
  localparam logic [6:0] V_FREEZE  = 7'b1111100;
  localparam logic [6:0] V_LDSTALL = 7'b1100010;
  localparam logic [6:0] V_FLUSH   = 7'b0000011;
  localparam logic [6:0] V_RESET   = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       rs_id = '0, rt_id = '0, rt_ex = '0;
  logic             use_rs_id = 1'b0, use_rt_id = 1'b0;
  logic             flag_mem_rd_ex = 1'b0, branch_taken_ex = 1'b0, mem_busy = 1'b0;
  logic             PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable;
  logic             bubble_ID_EX, flush_IF_ID, mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [6:0]       dut_vec;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: pending flush cycles, length of the current busy run,
  // sticky timeout and the saturating stall total.
  int pend, busy_run, m_stall;
  bit m_timeout;

  logic [6:0]       got_vec;
  logic [CNT_W-1:0] got_stall;
  logic             got_timeout;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .use_rs_id       (use_rs_id),
    .use_rt_id       (use_rt_id),
    .rt_ex           (rt_ex),
    .flag_mem_rd_ex  (flag_mem_rd_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .PC_enable       (PC_enable),
    .IF_ID_enable    (IF_ID_enable),
    .ID_EX_enable    (ID_EX_enable),
    .EX_MEM_enable   (EX_MEM_enable),
    .MEM_WB_enable   (MEM_WB_enable),
    .bubble_ID_EX    (bubble_ID_EX),
    .flush_IF_ID     (flush_IF_ID),
    .stall_count     (stall_count),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  assign dut_vec = {PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable,
                    MEM_WB_enable, bubble_ID_EX, flush_IF_ID};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    if (!flag_mem_rd_ex || rt_ex == 5'd0) return 1'b0;
    return (use_rs_id && rs_id == rt_ex) || (use_rt_id && rt_id == rt_ex);
  endfunction

  function automatic logic [6:0] model_vec();
    if (mem_busy)         return V_FREEZE;
    if (pend > 0)         return V_FLUSH;
    if (branch_taken_ex)  return V_FLUSH;
    if (model_load_use()) return V_LDSTALL;
    return V_NORMAL;
  endfunction

  task automatic model_reset();
    pend = 0; busy_run = 0; m_stall = 0; m_timeout = 1'b0;
  endtask

  task automatic model_advance();
    logic [6:0] v;
    v = model_vec();
    if (v != V_NORMAL && m_stall < (1 << CNT_W) - 1) m_stall++;
    if (mem_busy) begin
      if (busy_run >= MEM_TIMEOUT) m_timeout = 1'b1;
      busy_run++;
    end else begin
      busy_run = 0;
      if (pend > 0) pend--;
      else if (branch_taken_ex) pend = FLUSH_CYCLES - 1;
    end
  endtask

  // One clock cycle: drive after the rising edge, compare at the falling edge.
  task automatic cyc(input bit busy, input bit br, input bit rd, input logic [4:0] rtex,
                     input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt);
    @(posedge clk);
    #1;
    mem_busy = busy; branch_taken_ex = br; flag_mem_rd_ex = rd; rt_ex = rtex;
    rs_id = rs; rt_id = rt; use_rs_id = urs; use_rt_id = urt;
    @(negedge clk);
    got_vec = dut_vec; got_stall = stall_count; got_timeout = mem_timeout;
    check("ctrl_vs_model", 32'(got_vec), 32'(model_vec()));
    check("stall_vs_model", 32'(got_stall), 32'(m_stall));
    check("timeout_vs_model", 32'(got_timeout), 32'(m_timeout));
    model_advance();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    mem_busy = 0; branch_taken_ex = 0; flag_mem_rd_ex = 0;
    #1;
    check("reset_ctrl", 32'(dut_vec), 32'(V_RESET));
    check("reset_stall", 32'(stall_count), 32'd0);
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check("t1_reset_ctrl", 32'(dut_vec), 32'(V_RESET));
    check("t1_reset_stall", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    idle();
    check("t1_normal", 32'(got_vec), 32'(V_NORMAL));
    check("t1_stall0", 32'(got_stall), 32'd0);

    // 2: load-use on rs, then same with rt_ex = 0
    cyc(0, 0, 1, 5'd8, 5'd8, 5'd3, 1, 0);
    check("t2_ldstall", 32'(got_vec), 32'(V_LDSTALL));
    cyc(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    check("t2_r0_normal", 32'(got_vec), 32'(V_NORMAL));
    check("t2_stall1", 32'(got_stall), 32'd1);

    // 3: branch gives exactly two flush cycles; branch in cycle 2 is ignored
    cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("t3_flush1", 32'(got_vec), 32'(V_FLUSH));
    cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("t3_flush2", 32'(got_vec), 32'(V_FLUSH));
    idle();
    check("t3_normal", 32'(got_vec), 32'(V_NORMAL));
    check("t3_stall3", 32'(got_stall), 32'd3);

    // 4: branch, then three busy cycles: FLUSH, 3x FREEZE, FLUSH, NORMAL
    cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("t4_flush_a", 32'(got_vec), 32'(V_FLUSH));
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      check("t4_freeze", 32'(got_vec), 32'(V_FREEZE));
    end
    idle();
    check("t4_flush_b", 32'(got_vec), 32'(V_FLUSH));
    idle();
    check("t4_normal", 32'(got_vec), 32'(V_NORMAL));
    check("t4_stall8", 32'(got_stall), 32'd8);

    // 6: busy + branch + load-use -> FREEZE; then branch + load-use -> FLUSH x2
    cyc(1, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0);
    check("t6_freeze", 32'(got_vec), 32'(V_FREEZE));
    cyc(0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0);
    check("t6_flush1", 32'(got_vec), 32'(V_FLUSH));
    cyc(0, 0, 1, 5'd8, 5'd0, 5'd8, 0, 1);
    check("t6_flush2", 32'(got_vec), 32'(V_FLUSH));
    idle();
    check("t6_normal", 32'(got_vec), 32'(V_NORMAL));
    check("t6_stall11", 32'(got_stall), 32'd11);

    // Randomized traffic against the model (stall_count saturates at 8 bits)
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 40,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // 5: 256 consecutive busy cycles -> timeout, sticky afterwards
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      cyc(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      if (i == 256) check("t5_timeout_not_yet", 32'(got_timeout), 32'd0);
    end
    idle();
    check("t5_timeout_set", 32'(got_timeout), 32'd1);
    check("t5_stall_saturated", 32'(got_stall), 32'd255);
    for (int i = 0; i < 4; i++) idle();
    check("t5_timeout_sticky", 32'(got_timeout), 32'd1);

    // Asynchronous reset mid-flush: counters clear, first cycle after is NORMAL
    cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("rst_pre_flush", 32'(got_vec), 32'(V_FLUSH));
    do_reset();
    idle();
    check("rst_post_normal", 32'(got_vec), 32'(V_NORMAL));
    check("rst_post_timeout", 32'(got_timeout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
